serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor and magnitude comparator. Computes a − b LSB-first, one bit per clock, through a single full-subtractor cell and a registered borrow.
- Game logic uses it to compare the player's guess (a) against the secret number (b) and drive the higher/lower/equal VGA messages.
- Start/busy/done handshake; results held stable until the next accepted start.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor / comparator:
//   FSM state encoding, the default operand width and the default
//   bit-counter width.
//   No ports (package).
package serial_subtractor_pkg;

   // FIX is used only when SERIAL_SUBTRACTOR_ABS_EN is defined.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      FIX  = 2'd3
   } state_t;

   // The game's number range is 0..63.
   localparam int unsigned DEFAULT_WIDTH = 6;

   localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
//   One-bit combinational full subtractor. It computes a - b - b_in.
//   Ports:
//     a      minuend bit
//     b      subtrahend bit
//     b_in   incoming borrow
//     diff   difference bit
//     b_out  outgoing borrow
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic b_in,
   output logic diff,
   output logic b_out
);

   always_comb begin
      diff  = a ^ b ^ b_in;
      b_out = (~a & b) | (~(a ^ b) & b_in);
   end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor and magnitude comparator. It computes
//   a - b LSB-first, one bit per clock, through a single full_subtractor
//   cell and a registered borrow. It uses a start/busy/done handshake.
//   Results hold until the next accepted operation completes.
//   Optional feature macro: SERIAL_SUBTRACTOR_ABS_EN. When it is defined,
//   a FIX cycle is added and diff becomes |a - b|.
//   Ports:
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     start       request, sampled only in IDLE or DONE
//     a, b        minuend / subtrahend, captured on the accepted start
//     busy        operation in progress
//     done        one-cycle completion pulse
//     diff        (a - b) mod 2^WIDTH, or |a - b| with the macro
//     borrow_out  1 iff a < b
//     a_lt_b, a_eq_b, a_gt_b  comparison flags
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             a_lt_b,
   output logic             a_eq_b,
   output logic             a_gt_b
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic [CNT_W-1:0] cnt;

   logic             fs_diff;
   logic             fs_bout;
   logic [WIDTH-1:0] res_next;
   logic             last_bit;

   full_subtractor u_fs (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .b_in  (borrow),
      .diff  (fs_diff),
      .b_out (fs_bout)
   );

   // Each difference bit enters at the MSB, so after WIDTH shifts
   // the LSB-first bits sit in their natural positions.
   always_comb begin
      res_next = {fs_diff, res_sr[WIDTH-1:1]};
      last_bit = (cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         a_lt_b     <= 1'b0;
         a_eq_b     <= 1'b0;
         a_gt_b     <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a start exactly as IDLE does, so back-to-back
            // operations run with no bubble.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= fs_bout;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
`ifdef SERIAL_SUBTRACTOR_ABS_EN
                  state <= FIX;
`else
                  diff       <= res_next;
                  borrow_out <= fs_bout;
                  a_lt_b     <= fs_bout;
                  a_eq_b     <= (res_next == '0);
                  a_gt_b     <= !fs_bout && (res_next != '0);
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  state      <= DONE;
`endif
               end
            end

`ifdef SERIAL_SUBTRACTOR_ABS_EN
            // The raw result and the final borrow are already registered
            // here. A negative result is negated to get the magnitude.
            FIX: begin
               diff       <= borrow ? (~res_sr + WIDTH'(1)) : res_sr;
               borrow_out <= borrow;
               a_lt_b     <= borrow;
               a_eq_b     <= (res_sr == '0);
               a_gt_b     <= !borrow && (res_sr != '0);
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= DONE;
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. It uses directed and random
//   operands and compares against an arithmetic reference model.
//   Define SERIAL_SUBTRACTOR_ABS_EN to check the absolute-value build.
module tb_serial_subtractor;

   localparam int W = 6;
`ifdef SERIAL_SUBTRACTOR_ABS_EN
   localparam int LAT = W + 1;
   localparam bit ABS = 1'b1;
`else
   localparam int LAT = W;
   localparam bit ABS = 1'b0;
`endif
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         a_lt_b;
   logic         a_eq_b;
   logic         a_gt_b;

   int checks   = 0;
   int failures = 0;

   // Expected held outputs after the most recent completed operation.
   logic [W-1:0] h_diff;
   logic         h_bo, h_lt, h_eq, h_gt;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .a_lt_b     (a_lt_b),
      .a_eq_b     (a_eq_b),
      .a_gt_b     (a_gt_b)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference model: plain unsigned arithmetic on integers.
   task automatic model(input int av, input int bv);
      int d;
      d = av - bv;
      h_bo = (av < bv);
      h_lt = (av < bv);
      h_eq = (av == bv);
      h_gt = (av > bv);
      if (ABS) h_diff = W'((d < 0) ? -d : d);
      else     h_diff = W'((d + (1 << W)) % (1 << W));
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "_diff"}, 32'(diff),       32'(h_diff));
      check_val({tag, "_bo"},   32'(borrow_out), 32'(h_bo));
      check_val({tag, "_lt"},   32'(a_lt_b),     32'(h_lt));
      check_val({tag, "_eq"},   32'(a_eq_b),     32'(h_eq));
      check_val({tag, "_gt"},   32'(a_gt_b),     32'(h_gt));
   endtask

   // Counts edges after the start edge until done is seen. Until then,
   // outputs must hold their previous values and busy must stay high.
   // With inject_at > 0, a stray start with other operands is presented
   // so that it is sampled at edge inject_at+1.
   task automatic wait_done(input string tag, input int inject_at);
      int n;
      n = -1;
      for (int i = 1; i <= LAT + 4; i++) begin
         @(posedge clk); #1;
         if (inject_at > 0) begin
            start = (i == inject_at);
            if (i == inject_at) begin
               a = ~a;
               b = b + W'(7);
            end
         end
         if (done) begin
            n = i;
            break;
         end
         check_val({tag, "_busy"}, 32'(busy), 32'd1);
         check_val({tag, "_hold"}, 32'(diff), 32'(h_diff));
      end
      check_val({tag, "_lat"}, 32'(n), 32'(LAT));
   endtask

   task automatic run_op(input int av, input int bv, input string tag,
                         input int inject_at);
      a = W'(av);
      b = W'(bv);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_val({tag, "_busy0"}, 32'(busy), 32'd1);
      wait_done(tag, inject_at);
      start = 1'b0;
      model(av, bv);
      check_outputs(tag);
      check_val({tag, "_busyd"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check_val({tag, "_pulse"}, 32'(done), 32'd0);
      check_outputs({tag, "_idle"});
   endtask

   initial begin
      int pulses;
      int ra, rb;
      rst_n = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;

      // Asynchronous reset applied mid-cycle
      #7 rst_n = 1'b0;
      #1;
      h_diff = '0; h_bo = 0; h_lt = 0; h_eq = 0; h_gt = 0;
      check_outputs("rst");
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("idle");
      check_val("idle_busy", 32'(busy), 32'd0);

      // Directed cases
      run_op(45, 17, "d45_17", 0);
      run_op(17, 45, "d17_45", 0);
      run_op(33, 33, "d33_33", 0);
      run_op(0, MAXV, "dwrap", 0);
      run_op(MAXV, 0, "dmax0", 0);
      run_op(MAXV, MAXV, "dmaxmax", 0);

      // A stray start sampled at edge 3 must be ignored
      run_op(45, 17, "hz", 2);

      // A start held high through DONE gives a back-to-back operation
      a = W'(12); b = W'(40); start = 1'b1;
      @(posedge clk); #1;
      a = W'(50); b = W'(9);
      wait_done("b2b1", 0);
      model(12, 40);
      check_outputs("b2b1");
      @(posedge clk); #1;
      check_val("b2b_busy", 32'(busy), 32'd1);
      check_val("b2b_done", 32'(done), 32'd0);
      start = 1'b0;
      wait_done("b2b2", 0);
      model(50, 9);
      check_outputs("b2b2");
      @(posedge clk); #1;

      // Reset at RUN edge 4 aborts the operation without a done pulse
      a = W'(20); b = W'(5); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      h_diff = '0; h_bo = 0; h_lt = 0; h_eq = 0; h_gt = 0;
      check_outputs("abort");
      check_val("abort_busy", 32'(busy), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check_val("abort_nodone", 32'(pulses), 32'd0);
      run_op(10, 3, "post", 0);

      // Random operands
      for (int k = 0; k < 30; k++) begin
         ra = $urandom_range(0, MAXV);
         rb = (k % 5 == 0) ? ra : $urandom_range(0, MAXV);
         run_op(ra, rb, "rnd", 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_subtractor
